nway_cache_wb_buffer: RTL and testbench

Write-back buffer and memory adapter between the n-way cache controller's memory request port and main memory. Absorbs controller writes (dirty evictions, write-through) into a DEPTH-entry FIFO and drains them to memory in order. Reads forward from the buffer on address match, otherwise go to memory with priority over draining. Exactly one memory transaction outstanding.

---
 rtl/nway_cache_def_pkg.sv | 20 ++
 rtl/nway_cache_wb_store.sv | 79 +++++++
 rtl/nway_cache_wb_buffer.sv | 152 +++++++++++++++
 tb/tb_nway_cache_wb_buffer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nway_cache_def_pkg.sv
// Shared definitions for the n-way cache memory side: write-back buffer
// geometry, buffer entry layout and buffer controller states.
package nway_cache_def;

   localparam int WB_DEPTH  = 4;
   localparam int WB_ADDR_W = 32;
   localparam int WB_DATA_W = 32;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_type;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_WR_WAIT,
      WB_RD_WAIT
   } wb_state_type;

endpackage

// File: rtl/nway_cache_wb_store.sv
// Write-back buffer storage: circular FIFO of address/data entries with
// in-place overwrite and a parallel newest-match lookup.
module nway_cache_wb_store
   import nway_cache_def::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              ow,
   input  logic [PW-1:0]     ow_idx,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic [ADDR_W-1:0] match_addr,
   input  logic              excl_head,
   output logic              hit,
   output logic [PW-1:0]     hit_idx,
   output logic [DATA_W-1:0] hit_data,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic [CW-1:0]     count,
   output logic              full
);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            addr_q[tail] <= push_addr;
            data_q[tail] <= push_data;
            tail         <= tail + 1'b1;
         end
         if (ow) begin
            data_q[ow_idx] <= push_data;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Walk from oldest to newest so the last hit, closest to the tail, wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = head;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count) && !(excl_head && (k == 0)) &&
             (addr_q[head + PW'(k)] == match_addr)) begin
            hit     = 1'b1;
            hit_idx = head + PW'(k);
         end
      end
   end

   assign hit_data  = data_q[hit_idx];
   assign head_addr = addr_q[head];
   assign head_data = data_q[head];
   assign full      = (count == CW'(DEPTH));

endmodule

// File: rtl/nway_cache_wb_buffer.sv
// Write-back buffer and memory adapter for the n-way cache controller.
// Optional write coalescing is enabled by defining NWAY_WB_COALESCE_EN.
module nway_cache_wb_buffer
   import nway_cache_def::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int ADDR_W = WB_ADDR_W,
   parameter int DATA_W = WB_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_ready,
   output logic              mem_valid,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_state_type      state;
   logic              rd_pending;
   logic [ADDR_W-1:0] rd_addr;

   logic [CW-1:0]     count;
   logic              full;
   logic              hit;
   logic [PW-1:0]     hit_idx;
   logic [DATA_W-1:0] hit_data;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;

   logic accept;
   logic wr_acc;
   logic rd_hit;
   logic rd_miss;
   logic push;
   logic pop;
   logic ow;
   logic excl_head;

   assign req_ready = !rst && !full && !rd_pending;
   assign accept    = req_valid && req_ready;
   assign wr_acc    = accept && req_rw;
   assign rd_hit    = accept && !req_rw && hit;
   assign rd_miss   = accept && !req_rw && !hit;
   assign pop       = (state == WB_WR_WAIT) && mem_ack;

`ifdef NWAY_WB_COALESCE_EN
   // The head is off limits to writes once its drain is launched or in flight,
   // otherwise the new data would never reach memory.
   assign excl_head = req_rw &&
                      ((state == WB_WR_WAIT) || ((state == WB_IDLE) && (count != '0)));
   assign push      = wr_acc && !hit;
   assign ow        = wr_acc && hit;
`else
   assign excl_head = 1'b0;
   assign push      = wr_acc;
   assign ow        = 1'b0;
`endif

   nway_cache_wb_store #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_store (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .ow         (ow),
      .ow_idx     (hit_idx),
      .push_addr  (req_addr),
      .push_data  (req_data),
      .match_addr (req_addr),
      .excl_head  (excl_head),
      .hit        (hit),
      .hit_idx    (hit_idx),
      .hit_data   (hit_data),
      .head_addr  (head_addr),
      .head_data  (head_data),
      .count      (count),
      .full       (full)
   );

   // Reads take priority over draining; only one memory transaction at a time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WB_IDLE;
         rd_pending <= 1'b0;
         rd_addr    <= '0;
         resp_ready <= 1'b0;
         resp_data  <= '0;
         mem_valid  <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         resp_ready <= 1'b0;
         if (rd_hit) begin
            resp_ready <= 1'b1;
            resp_data  <= hit_data;
         end
         if (rd_miss) begin
            rd_pending <= 1'b1;
            rd_addr    <= req_addr;
         end
         case (state)
            WB_IDLE: begin
               if (rd_pending || rd_miss) begin
                  state     <= WB_RD_WAIT;
                  mem_valid <= 1'b1;
                  mem_rw    <= 1'b0;
                  mem_addr  <= rd_pending ? rd_addr : req_addr;
               end else if (count != '0) begin
                  state     <= WB_WR_WAIT;
                  mem_valid <= 1'b1;
                  mem_rw    <= 1'b1;
                  mem_addr  <= head_addr;
                  mem_wdata <= head_data;
               end
            end
            WB_WR_WAIT: begin
               if (mem_ack) begin
                  mem_valid <= 1'b0;
                  state     <= WB_IDLE;
               end
            end
            WB_RD_WAIT: begin
               if (mem_ack) begin
                  mem_valid  <= 1'b0;
                  resp_ready <= 1'b1;
                  resp_data  <= mem_rdata;
                  rd_pending <= 1'b0;
                  state      <= WB_IDLE;
               end
            end
            default: state <= WB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nway_cache_wb_buffer.sv
// Directed self-checking bench for nway_cache_wb_buffer (DEPTH=4); expected
// counts follow NWAY_WB_COALESCE_EN when it is defined.
module tb_nway_cache_wb_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_rw;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        req_ready;
   logic [31:0] resp_data;
   logic        resp_ready;
   logic        mem_valid;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int          checks = 0;
   int          errors = 0;
   int          rd_issues = 0;
   logic [31:0] wr_addr_log [$];
   logic [31:0] wr_data_log [$];

   always #5 clk = ~clk;

   nway_cache_wb_buffer #(
      .DEPTH  (4),
      .ADDR_W (32),
      .DATA_W (32)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_rw     (req_rw),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .mem_valid  (mem_valid),
      .mem_rw     (mem_rw),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   // Memory-side log of completed writes and issued reads.
   always @(negedge clk) begin
      if (mem_valid && mem_ack && mem_rw) begin
         wr_addr_log.push_back(mem_addr);
         wr_data_log.push_back(mem_wdata);
      end
      if (mem_valid && !mem_rw) rd_issues++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic rw,
                                input logic [31:0] addr, input logic [31:0] data);
      req_valid = valid;
      req_rw    = rw;
      req_addr  = addr;
      req_data  = data;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic drainOne();
      int wait_cycles = 0;
      while (!mem_valid && wait_cycles < 20) begin
         tick();
         wait_cycles++;
      end
      checkOutput("drain_valid", {63'd0, mem_valid}, 64'd1);
      if (mem_valid) begin
         mem_ack = 1'b1;
         tick();
         mem_ack = 1'b0;
      end
   endtask

   logic [31:0] exp_addr [4] = '{32'h400, 32'h404, 32'h408, 32'h40C};
   logic [31:0] exp_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
   int          exp_cnt;

   initial begin
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      applyStimulus(1'b0, 1'b0, '0, '0);

      // Reset state
      tick();
      tick();
      checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
      checkOutput("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
      checkOutput("rst_resp_ready", {63'd0, resp_ready}, 64'd0);
      checkOutput("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      checkOutput("rst_count", 64'(u_dut.u_store.count), 64'd0);
      rst = 1'b0;
      tick();
      checkOutput("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

      // Single write drained with a delayed ack
      applyStimulus(1'b1, 1'b1, 32'h100, 32'hAAAA0001);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("w1_count_after_accept", 64'(u_dut.u_store.count), 64'd1);
      tick();
      checkOutput("w1_mem_valid", {63'd0, mem_valid}, 64'd1);
      checkOutput("w1_mem_rw", {63'd0, mem_rw}, 64'd1);
      checkOutput("w1_mem_addr", {32'd0, mem_addr}, 64'h100);
      checkOutput("w1_mem_wdata", {32'd0, mem_wdata}, 64'hAAAA0001);
      tick();
      tick();
      checkOutput("w1_mem_valid_held", {63'd0, mem_valid}, 64'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("w1_mem_valid_after_ack", {63'd0, mem_valid}, 64'd0);
      checkOutput("w1_count_after_ack", 64'(u_dut.u_store.count), 64'd0);
      checkOutput("w1_log_size", 64'(wr_addr_log.size()), 64'd1);
      checkOutput("w1_log_addr", {32'd0, wr_addr_log[0]}, 64'h100);
      checkOutput("w1_log_data", {32'd0, wr_data_log[0]}, 64'hAAAA0001);
      wr_addr_log.delete();
      wr_data_log.delete();

      // Fill to DEPTH with drain stalled, one ack frees a slot
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, exp_addr[i], exp_data[i]);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("full_req_ready", {63'd0, req_ready}, 64'd0);
      checkOutput("full_count", 64'(u_dut.u_store.count), 64'd4);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("full_pop_req_ready", {63'd0, req_ready}, 64'd1);
      checkOutput("full_pop_count", 64'(u_dut.u_store.count), 64'd3);
      for (int i = 0; i < 3; i++) drainOne();
      checkOutput("order_log_size", 64'(wr_addr_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput("order_addr", {32'd0, wr_addr_log[i]}, {32'd0, exp_addr[i]});
         checkOutput("order_data", {32'd0, wr_data_log[i]}, {32'd0, exp_data[i]});
      end
      wr_addr_log.delete();
      wr_data_log.delete();

      // Read forwarded from buffer, no memory read
      tick();
      applyStimulus(1'b1, 1'b1, 32'h200, 32'h1234);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h200, '0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("fwd_resp_ready", {63'd0, resp_ready}, 64'd1);
      checkOutput("fwd_resp_data", {32'd0, resp_data}, 64'h1234);
      tick();
      checkOutput("fwd_resp_pulse", {63'd0, resp_ready}, 64'd0);
      drainOne();
      checkOutput("fwd_no_mem_read", 64'(rd_issues), 64'd0);
      tick();

      // Read miss with same-cycle ack
      applyStimulus(1'b1, 1'b0, 32'h300, '0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("miss_mem_valid", {63'd0, mem_valid}, 64'd1);
      checkOutput("miss_mem_rw", {63'd0, mem_rw}, 64'd0);
      checkOutput("miss_mem_addr", {32'd0, mem_addr}, 64'h300);
      checkOutput("miss_req_ready", {63'd0, req_ready}, 64'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      checkOutput("miss_resp_ready", {63'd0, resp_ready}, 64'd1);
      checkOutput("miss_resp_data", {32'd0, resp_data}, 64'hDEADBEEF);
      checkOutput("miss_mem_valid_after", {63'd0, mem_valid}, 64'd0);
      wr_addr_log.delete();
      wr_data_log.delete();
      tick();

      // Duplicate address writes behind an in-flight drain, then read newest
      applyStimulus(1'b1, 1'b1, 32'h20, 32'h9);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h10, 32'h1);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h10, 32'h2);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h10, '0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
`ifdef NWAY_WB_COALESCE_EN
      exp_cnt = 2;
`else
      exp_cnt = 3;
`endif
      checkOutput("dup_resp_ready", {63'd0, resp_ready}, 64'd1);
      checkOutput("dup_resp_data", {32'd0, resp_data}, 64'h2);
      checkOutput("dup_count", 64'(u_dut.u_store.count), 64'(exp_cnt));
      for (int i = 0; i < exp_cnt; i++) drainOne();
      checkOutput("dup_log_size", 64'(wr_addr_log.size()), 64'(exp_cnt));
      checkOutput("dup_log0_addr", {32'd0, wr_addr_log[0]}, 64'h20);
`ifdef NWAY_WB_COALESCE_EN
      checkOutput("dup_log1_data", {32'd0, wr_data_log[1]}, 64'h2);
`else
      checkOutput("dup_log1_data", {32'd0, wr_data_log[1]}, 64'h1);
      checkOutput("dup_log2_data", {32'd0, wr_data_log[2]}, 64'h2);
`endif
      wr_addr_log.delete();
      wr_data_log.delete();
      tick();

      // Reset in the middle of a drain, late ack ignored
      applyStimulus(1'b1, 1'b1, 32'h500, 32'h5);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h504, 32'h6);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("mid_mem_valid", {63'd0, mem_valid}, 64'd1);
      checkOutput("mid_count", 64'(u_dut.u_store.count), 64'd2);
      rst = 1'b1;
      tick();
      checkOutput("mid_rst_mem_valid", {63'd0, mem_valid}, 64'd0);
      checkOutput("mid_rst_mem_rw", {63'd0, mem_rw}, 64'd0);
      checkOutput("mid_rst_mem_addr", {32'd0, mem_addr}, 64'd0);
      checkOutput("mid_rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
      checkOutput("mid_rst_count", 64'(u_dut.u_store.count), 64'd0);
      checkOutput("mid_rst_req_ready", {63'd0, req_ready}, 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("mid_post_req_ready", {63'd0, req_ready}, 64'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("late_ack_count", 64'(u_dut.u_store.count), 64'd0);
      checkOutput("late_ack_mem_valid", {63'd0, mem_valid}, 64'd0);
      tick();
      checkOutput("late_ack_idle", {63'd0, mem_valid}, 64'd0);
      checkOutput("late_ack_log", 64'(wr_addr_log.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
